// File: rtl/tt_um_fsm_seq.sv
// Four-state display sequencer: IDLE -> COUNT (prescaled ticks) -> WAIT (ack) -> DONE (ack) -> IDLE.
// Optional WAIT timeout enabled by defining FSM_TIMEOUT_EN.
module tt_um_fsm_seq #(
   parameter int CNT_W         = 8,
   parameter int DIV_W         = 24,
   parameter int TICK_DIV      = 10_000_000,
   parameter int OUT_W         = 8,
   parameter int TIMEOUT_TICKS = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic             start,
   input  logic             ack,
   input  logic [CNT_W-1:0] count_target,
   output logic [OUT_W-1:0] code_out,
   output logic [1:0]       state_out,
   output logic [CNT_W-1:0] count_out,
   output logic             busy,
   output logic             done_pulse,
   output logic             timeout_flag
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_COUNT = 2'd1,
      S_WAIT  = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [CNT_W-1:0]   tgt_q, tgt_d;
   logic [DIV_W-1:0]   div_q, div_d;
   logic               start_q, ack_q;
   logic               done_pulse_q, done_pulse_d;
   logic               start_rise, ack_rise, tick;
   logic [CNT_W-1:0]   cnt_inc;

   assign start_rise = start & ~start_q;
   assign ack_rise   = ack & ~ack_q;
   assign tick       = (div_q == DIV_W'(TICK_DIV - 1));
   assign cnt_inc    = cnt_q + CNT_W'(1);

`ifdef FSM_TIMEOUT_EN
   localparam int TMO_W = $clog2(TIMEOUT_TICKS + 1);
   logic [TMO_W-1:0] tmo_q, tmo_d;
   logic [TMO_W-1:0] tmo_inc;
   logic             tflag_q, tflag_d;
   assign tmo_inc = tmo_q + TMO_W'(1);
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         tgt_q        <= '0;
         div_q        <= '0;
         start_q      <= 1'b0;
         ack_q        <= 1'b0;
         done_pulse_q <= 1'b0;
`ifdef FSM_TIMEOUT_EN
         tmo_q        <= '0;
         tflag_q      <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         tgt_q        <= tgt_d;
         div_q        <= div_d;
         start_q      <= start;
         ack_q        <= ack;
         done_pulse_q <= done_pulse_d;
`ifdef FSM_TIMEOUT_EN
         tmo_q        <= tmo_d;
         tflag_q      <= tflag_d;
`endif
      end
   end

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      tgt_d        = tgt_q;
      div_d        = div_q;
      done_pulse_d = 1'b0;
`ifdef FSM_TIMEOUT_EN
      tmo_d        = tmo_q;
      tflag_d      = tflag_q;
`endif
      if (enable) begin
         case (state_q)
            S_IDLE: begin
               if (start_rise) begin
                  tgt_d   = count_target;
                  cnt_d   = '0;
                  div_d   = '0;
                  state_d = (count_target == '0) ? S_WAIT : S_COUNT;
`ifdef FSM_TIMEOUT_EN
                  tmo_d   = '0;
`endif
               end
            end
            S_COUNT: begin
               if (tick) begin
                  div_d = '0;
                  cnt_d = cnt_inc;
                  if (cnt_inc == tgt_q) begin
                     state_d = S_WAIT;
`ifdef FSM_TIMEOUT_EN
                     tmo_d   = '0;
`endif
                  end
               end else begin
                  div_d = div_q + DIV_W'(1);
               end
            end
            S_WAIT: begin
               // ack_rise takes priority over a coinciding final timeout tick
               if (ack_rise) begin
                  state_d      = S_DONE;
                  done_pulse_d = 1'b1;
               end
`ifdef FSM_TIMEOUT_EN
               else if (tick) begin
                  div_d = '0;
                  tmo_d = tmo_inc;
                  if (tmo_inc == TMO_W'(TIMEOUT_TICKS)) begin
                     state_d      = S_DONE;
                     done_pulse_d = 1'b1;
                     tflag_d      = 1'b1;
                  end
               end else begin
                  div_d = div_q + DIV_W'(1);
               end
`endif
            end
            S_DONE: begin
               if (ack_rise) begin
                  state_d = S_IDLE;
                  cnt_d   = '0;
`ifdef FSM_TIMEOUT_EN
                  tflag_d = 1'b0;
`endif
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_comb begin
      case (state_q)
         S_COUNT: code_out = OUT_W'(8'h0A);
         S_WAIT:  code_out = OUT_W'(8'h05);
         S_DONE:  code_out = OUT_W'(8'h0F);
         default: code_out = OUT_W'(8'h00);
      endcase
   end

   assign state_out  = state_q;
   assign count_out  = cnt_q;
   assign busy       = (state_q == S_COUNT) || (state_q == S_WAIT);
   assign done_pulse = done_pulse_q;
`ifdef FSM_TIMEOUT_EN
   assign timeout_flag = tflag_q;
`else
   assign timeout_flag = 1'b0;
`endif

endmodule

// File: tb/tb_tt_um_fsm_seq.sv
// Directed self-checking bench for tt_um_fsm_seq with TICK_DIV=4 (timeout case with FSM_TIMEOUT_EN).
module tb_tt_um_fsm_seq;

   logic       clk = 1'b0;
   logic       reset;
   logic       enable;
   logic       start;
   logic       ack;
   logic [7:0] count_target;
   logic [7:0] code_out;
   logic [1:0] state_out;
   logic [7:0] count_out;
   logic       busy;
   logic       done_pulse;
   logic       timeout_flag;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   tt_um_fsm_seq #(
      .CNT_W(8),
      .DIV_W(24),
      .TICK_DIV(4),
      .OUT_W(8),
      .TIMEOUT_TICKS(2)
   ) dut (
      .clk(clk),
      .reset(reset),
      .enable(enable),
      .start(start),
      .ack(ack),
      .count_target(count_target),
      .code_out(code_out),
      .state_out(state_out),
      .count_out(count_out),
      .busy(busy),
      .done_pulse(done_pulse),
      .timeout_flag(timeout_flag)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // advance n rising edges, then settle 1 time unit
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk_state(input string tag, input logic [1:0] st, input logic [7:0] code,
                            input logic [7:0] cnt, input logic bsy);
      chk({tag, ".state"}, 32'(state_out), 32'(st));
      chk({tag, ".code"},  32'(code_out),  32'(code));
      chk({tag, ".count"}, 32'(count_out), 32'(cnt));
      chk({tag, ".busy"},  32'(busy),      32'(bsy));
   endtask

   initial begin
      #20000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      reset = 1'b0; enable = 1'b1; start = 1'b0; ack = 1'b0; count_target = 8'd3;
      step(2);
      chk_state("reset", 2'd0, 8'h00, 8'd0, 1'b0);
      chk("reset.pulse", 32'(done_pulse), 32'd0);
      chk("reset.tflag", 32'(timeout_flag), 32'd0);
      reset = 1'b1;
      step(1);

      // ack edge in IDLE is ignored
      ack = 1'b1; step(1);
      chk("idle_ack", 32'(state_out), 32'd0);
      ack = 1'b0;

      // target=3 run: 12 clk in COUNT then WAIT
      start = 1'b1; step(1);
      chk_state("cnt_entry", 2'd1, 8'h0A, 8'd0, 1'b1);
      step(11);
      chk_state("cnt_last", 2'd1, 8'h0A, 8'd2, 1'b1);
      step(1);
      chk_state("wait3", 2'd2, 8'h05, 8'd3, 1'b1);
      chk("wait3.tflag", 32'(timeout_flag), 32'd0);

      // ack held 5 cycles: single DONE entry, one-cycle pulse
      ack = 1'b1; step(1);
      chk_state("done", 2'd3, 8'h0F, 8'd3, 1'b0);
      chk("done.pulse1", 32'(done_pulse), 32'd1);
      step(1);
      chk("done.pulse2", 32'(done_pulse), 32'd0);
      step(3);
      chk("done.held", 32'(state_out), 32'd3);
      ack = 1'b0; step(1);
      ack = 1'b1; step(1);
      chk_state("back_idle", 2'd0, 8'h00, 8'd0, 1'b0);

      // target=0: straight to WAIT with count 0
      start = 1'b0; count_target = 8'd0; step(1);
      start = 1'b1; step(1);
      chk_state("t0_wait", 2'd2, 8'h05, 8'd0, 1'b1);
      ack = 1'b0; step(1);
      ack = 1'b1; step(1);
      chk("t0_done", 32'(state_out), 32'd3);
      ack = 1'b0; step(1);
      ack = 1'b1; step(1);
      chk("t0_idle", 32'(state_out), 32'd0);
      ack = 1'b0;

      // enable=0 for 10 clk mid-COUNT: WAIT reached after 22 clk
      start = 1'b0; count_target = 8'd3; step(1);
      start = 1'b1; step(1);
      step(4);
      chk_state("frz_pre", 2'd1, 8'h0A, 8'd1, 1'b1);
      enable = 1'b0; step(10);
      chk_state("frz_hold", 2'd1, 8'h0A, 8'd1, 1'b1);
      enable = 1'b1; step(7);
      chk_state("frz_last", 2'd1, 8'h0A, 8'd2, 1'b1);
      step(1);
      chk_state("frz_wait", 2'd2, 8'h05, 8'd3, 1'b1);

      // ack edge while disabled is lost
      enable = 1'b0; ack = 1'b1; step(2);
      enable = 1'b1; step(2);
      chk("lost_ack", 32'(state_out), 32'd2);
      ack = 1'b0; step(1);
      ack = 1'b1; step(1);
      chk("late_ack", 32'(state_out), 32'd3);
      ack = 1'b0; step(1);
      ack = 1'b1; step(1);
      chk("late_idle", 32'(state_out), 32'd0);
      ack = 1'b0;

      // asynchronous reset mid-COUNT
      start = 1'b0; step(1);
      start = 1'b1; step(3);
      chk("pre_rst", 32'(state_out), 32'd1);
      reset = 1'b0; #1;
      chk_state("async_rst", 2'd0, 8'h00, 8'd0, 1'b0);
      step(1);
      reset = 1'b1; start = 1'b0; step(1);

`ifdef FSM_TIMEOUT_EN
      // timeout: DONE 8 clk after WAIT entry, sticky flag until DONE->IDLE
      count_target = 8'd1;
      start = 1'b1; step(1);
      step(4);
      chk("tmo_wait", 32'(state_out), 32'd2);
      step(7);
      chk("tmo_still", 32'(state_out), 32'd2);
      step(1);
      chk("tmo_done", 32'(state_out), 32'd3);
      chk("tmo_flag", 32'(timeout_flag), 32'd1);
      chk("tmo_pulse", 32'(done_pulse), 32'd1);
      step(3);
      chk("tmo_sticky", 32'(timeout_flag), 32'd1);
      ack = 1'b1; step(1);
      chk("tmo_idle", 32'(state_out), 32'd0);
      chk("tmo_clr", 32'(timeout_flag), 32'd0);
      ack = 1'b0; start = 1'b0; step(1);
`endif

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
